// File: rtl/vg_pkg.sv
// Shared vector-generator definitions: default widths, DVG opcodes and the
// sequencer state encoding. Also imported by the draw engine.
package vg_pkg;

    localparam int unsigned VG_AW          = 12;
    localparam int unsigned VG_DW          = 16;
    localparam int unsigned VG_STACK_DEPTH = 4;
    localparam int unsigned VG_OPW         = 4;

    // Opcodes 0-9 are VCTR with the opcode doubling as the scale.
    localparam logic [VG_OPW-1:0] OP_VCTR_MAX = 4'h9;
    localparam logic [VG_OPW-1:0] OP_LABS     = 4'hA;
    localparam logic [VG_OPW-1:0] OP_HALT     = 4'hB;
    localparam logic [VG_OPW-1:0] OP_JSRL     = 4'hC;
    localparam logic [VG_OPW-1:0] OP_RTSL     = 4'hD;
    localparam logic [VG_OPW-1:0] OP_JMPL     = 4'hE;
    localparam logic [VG_OPW-1:0] OP_SVEC     = 4'hF;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT0,
        ST_DEC0,
        ST_WAIT1,
        ST_ISSUE,
        ST_CALL_ADV,
        ST_CALL_PUSH,
        ST_HALTED
    } vg_state_e;

endpackage

// File: rtl/vg_fetch_decode_if.sv
// Sequencer bus: pc-block control/readback, vector memory read data and the
// command handshake to the draw engine.
//  master: the sequencer (drives pc strobes and commands)
//  slave : pc block / memory / draw engine side
interface vg_fetch_decode_if #(
    parameter int unsigned AW = 12,
    parameter int unsigned DW = 16
);
    import vg_pkg::*;

    logic [AW-1:0]     pc_addr;
    logic [DW-1:0]     mem_data;
    logic              latch0;
    logic              load_pc;
    logic              dmaload;
    logic              dmapush;
    logic [AW-1:0]     count_in;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [VG_OPW-1:0] cmd_op;
    logic [DW-1:0]     cmd_w0;
    logic [DW-1:0]     cmd_w1;

    modport master (
        input  pc_addr, mem_data, cmd_ready,
        output latch0, load_pc, dmaload, dmapush, count_in,
        output cmd_valid, cmd_op, cmd_w0, cmd_w1
    );

    modport slave (
        output pc_addr, mem_data, cmd_ready,
        input  latch0, load_pc, dmaload, dmapush, count_in,
        input  cmd_valid, cmd_op, cmd_w0, cmd_w1
    );

endinterface

// File: rtl/vg_fetch_decode_op_decode.sv
// Opcode classifier (combinational).
//  op      : display word bits [15:12]
//  is_vec  : VCTR/LABS/SVEC, handed to the draw engine
//  nwords  : words in a vector command (2 for VCTR/LABS, 1 otherwise)
//  is_flow : HALT/JSRL/RTSL/JMPL, handled inside the sequencer
module vg_op_decode
    import vg_pkg::*;
(
    input  logic [VG_OPW-1:0] op,
    output logic              is_vec,
    output logic [1:0]        nwords,
    output logic              is_flow
);

    always_comb begin
        is_vec  = 1'b0;
        nwords  = 2'd1;
        is_flow = 1'b0;
        if (op <= OP_VCTR_MAX || op == OP_LABS) begin
            is_vec = 1'b1;
            nwords = 2'd2;
        end else if (op == OP_SVEC) begin
            is_vec = 1'b1;
        end else begin
            is_flow = 1'b1;
        end
    end

endmodule

// File: rtl/vg_fetch_decode.sv
// Display-list sequencer for the vector generator. Fetches display words via
// the pc block, decodes DVG opcodes, steers the pc (step/jump/call/return) and
// hands vector commands to the draw engine.
//  clk, reset      : clock, asynchronous active-low reset
//  go, start_addr  : start pulse and entry address (IDLE/HALTED only)
//  halted          : HALT reached or error; cleared by go
//  stack_err       : sticky return-stack over/underflow; cleared by go
//  bus (master)    : pc strobes, memory read data, command handshake
module vg_fetch_decode
    import vg_pkg::*;
#(
    parameter int unsigned AW          = VG_AW,
    parameter int unsigned DW          = VG_DW,
    parameter int unsigned STACK_DEPTH = VG_STACK_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic [AW-1:0]     start_addr,
    output logic              halted,
    output logic              stack_err,
    vg_fetch_decode_if.master bus
);

    localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);

    vg_state_e         state;
    logic [DEPTH_W-1:0] depth;
    logic [DW-1:0]      w0;
    logic [1:0]         wcnt;

    logic [VG_OPW-1:0]  op;
    logic               is_vec;
    logic [1:0]         nwords;
    logic               is_flow;

    assign op = w0[DW-1 -: VG_OPW];

    vg_op_decode u_op_decode (
        .op      (op),
        .is_vec  (is_vec),
        .nwords  (nwords),
        .is_flow (is_flow)
    );

    // Sequencer FSM. Strobes are pulses: cleared every cycle unless re-armed.
    // wcnt counts the cycles left before mem_data reflects the settled pc:
    // 2 when the pc strobe fires in the first wait cycle, 1 when it already
    // fired in the previous state. cmd_w1 doubles as the second-word register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            depth         <= '0;
            w0            <= '0;
            wcnt          <= '0;
            halted        <= 1'b0;
            stack_err     <= 1'b0;
            bus.latch0    <= 1'b0;
            bus.load_pc   <= 1'b0;
            bus.dmaload   <= 1'b0;
            bus.dmapush   <= 1'b0;
            bus.count_in  <= '0;
            bus.cmd_valid <= 1'b0;
            bus.cmd_op    <= '0;
            bus.cmd_w0    <= '0;
            bus.cmd_w1    <= '0;
        end else begin
            bus.latch0  <= 1'b0;
            bus.load_pc <= 1'b0;
            bus.dmaload <= 1'b0;
            bus.dmapush <= 1'b0;
            case (state)
                ST_IDLE, ST_HALTED: begin
                    if (go) begin
                        bus.count_in <= start_addr;
                        bus.load_pc  <= 1'b1;
                        bus.dmaload  <= 1'b1;
                        depth        <= '0;
                        halted       <= 1'b0;
                        stack_err    <= 1'b0;
                        state        <= ST_START;
                    end
                end
                ST_START: begin
                    wcnt  <= 2'd1;
                    state <= ST_WAIT0;
                end
                ST_WAIT0: begin
                    if (wcnt == 2'd0) begin
                        w0    <= bus.mem_data;
                        state <= ST_DEC0;
                    end else begin
                        wcnt <= wcnt - 2'd1;
                    end
                end
                ST_DEC0: begin
                    if (is_vec) begin
                        bus.latch0 <= 1'b1;
                        if (nwords == 2'd2) begin
                            wcnt  <= 2'd2;
                            state <= ST_WAIT1;
                        end else begin
                            bus.cmd_valid <= 1'b1;
                            bus.cmd_op    <= op;
                            bus.cmd_w0    <= w0;
                            bus.cmd_w1    <= '0;
                            state         <= ST_ISSUE;
                        end
                    end else if (is_flow) begin
                        case (op)
                            OP_JSRL: begin
                                if (depth == DEPTH_W'(STACK_DEPTH)) begin
                                    stack_err <= 1'b1;
                                    halted    <= 1'b1;
                                    state     <= ST_HALTED;
                                end else begin
                                    bus.latch0 <= 1'b1;
                                    depth      <= depth + DEPTH_W'(1);
                                    state      <= ST_CALL_ADV;
                                end
                            end
                            OP_RTSL: begin
                                if (depth == '0) begin
                                    stack_err <= 1'b1;
                                    halted    <= 1'b1;
                                    state     <= ST_HALTED;
                                end else begin
                                    bus.dmaload <= 1'b1;
                                    depth       <= depth - DEPTH_W'(1);
                                    wcnt        <= 2'd2;
                                    state       <= ST_WAIT0;
                                end
                            end
                            OP_JMPL: begin
                                bus.count_in <= w0[AW-1:0];
                                bus.load_pc  <= 1'b1;
                                bus.dmaload  <= 1'b1;
                                wcnt         <= 2'd2;
                                state        <= ST_WAIT0;
                            end
                            default: begin
                                halted <= 1'b1;
                                state  <= ST_HALTED;
                            end
                        endcase
                    end
                end
                ST_WAIT1: begin
                    if (wcnt == 2'd0) begin
                        bus.latch0    <= 1'b1;
                        bus.cmd_valid <= 1'b1;
                        bus.cmd_op    <= op;
                        bus.cmd_w0    <= w0;
                        bus.cmd_w1    <= bus.mem_data;
                        state         <= ST_ISSUE;
                    end else begin
                        wcnt <= wcnt - 2'd1;
                    end
                end
                // latch0 fired on entry, so pc_addr here is the return address.
                ST_CALL_ADV: begin
                    bus.dmapush <= 1'b1;
                    state       <= ST_CALL_PUSH;
                end
                ST_CALL_PUSH: begin
                    bus.count_in <= w0[AW-1:0];
                    bus.load_pc  <= 1'b1;
                    bus.dmaload  <= 1'b1;
                    wcnt         <= 2'd2;
                    state        <= ST_WAIT0;
                end
                ST_ISSUE: begin
                    if (bus.cmd_ready) begin
                        bus.cmd_valid <= 1'b0;
                        wcnt          <= 2'd1;
                        state         <= ST_WAIT0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vg_fetch_decode.sv
// Bench for vg_fetch_decode: pc-block + ROM model, scoreboard of expected
// draw commands produced by a display-list interpreter, directed and random
// display lists.
module tb_vg_fetch_decode;
    import vg_pkg::*;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 16;

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] w0;
        logic [15:0] w1;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          go;
    logic [AW-1:0] start_addr;
    logic          halted;
    logic          stack_err;

    vg_fetch_decode_if #(.AW(AW), .DW(DW)) bus ();

    vg_fetch_decode #(.AW(AW), .DW(DW), .STACK_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .go         (go),
        .start_addr (start_addr),
        .halted     (halted),
        .stack_err  (stack_err),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // ---------------- pc block + vector ROM model ----------------
    logic [15:0] rom [0:4095];
    logic [11:0] stk [0:15];
    int          sp     = 0;
    int          n_push = 0;
    int          n_pop  = 0;
    int          viol   = 0;
    logic [11:0] last_push = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.pc_addr  <= '0;
            bus.mem_data <= '0;
            sp           <= 0;
        end else begin
            bus.mem_data <= rom[bus.pc_addr];
            if (int'(bus.latch0) + int'(bus.dmapush) + int'(bus.dmaload) > 1 ||
                (bus.load_pc && !bus.dmaload))
                viol <= viol + 1;
            if (bus.latch0)
                bus.pc_addr <= bus.pc_addr + 12'd1;
            else if (bus.load_pc && bus.dmaload)
                bus.pc_addr <= bus.count_in;
            else if (bus.dmaload) begin
                n_pop <= n_pop + 1;
                if (sp == 0) viol <= viol + 1;
                else begin
                    bus.pc_addr <= stk[4'(sp - 1)];
                    sp          <= sp - 1;
                end
            end
            if (bus.dmapush) begin
                n_push    <= n_push + 1;
                last_push <= bus.pc_addr;
                if (sp >= 16) viol <= viol + 1;
                else begin
                    stk[4'(sp)] <= bus.pc_addr;
                    sp          <= sp + 1;
                end
            end
        end
    end

    // ---------------- draw-engine ready driver ----------------
    int rdy_mode = 0;   // 0 always ready, 1 random, 2 never ready

    initial begin
        bus.cmd_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.cmd_ready = 1'b1;
                1:       bus.cmd_ready = 1'($urandom_range(0, 1));
                default: bus.cmd_ready = 1'b0;
            endcase
        end
    end

    // ---------------- reference model ----------------
    cmd_t        exp_q[$];
    logic [11:0] exp_pc;
    logic        exp_err;
    int          exp_push;
    int          exp_pop;
    logic [11:0] exp_last_push;

    // Interprets the display list from rom, queuing every vector command.
    task automatic ref_run(input logic [11:0] start);
        logic [11:0] pc;
        logic [11:0] rs[$];
        logic [15:0] w;
        logic [3:0]  o;
        pc = start;
        exp_err = 1'b0; exp_push = 0; exp_pop = 0; exp_last_push = '0;
        for (int step = 0; step < 2000; step++) begin
            w = rom[pc];
            o = w[15:12];
            if (o <= 4'h9 || o == 4'hA) begin
                exp_q.push_back('{o, w, rom[pc + 12'd1]});
                pc = pc + 12'd2;
            end else if (o == 4'hF) begin
                exp_q.push_back('{o, w, 16'h0});
                pc = pc + 12'd1;
            end else if (o == 4'hB) begin
                break;
            end else if (o == 4'hC) begin
                if (rs.size() == 4) begin exp_err = 1'b1; break; end
                rs.push_back(pc + 12'd1);
                exp_push++;
                exp_last_push = pc + 12'd1;
                pc = w[11:0];
            end else if (o == 4'hD) begin
                if (rs.size() == 0) begin exp_err = 1'b1; break; end
                pc = rs.pop_back();
                exp_pop++;
            end else begin
                pc = w[11:0];
            end
        end
        exp_pc = pc;
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic        pv;
        logic        pr;
        logic [35:0] pcmd;
        cmd_t        e;
        pv = 1'b0; pr = 1'b0; pcmd = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0;
            end else begin
                if (pv && !pr)
                    chk("cmd_hold",
                        64'({bus.cmd_valid, bus.cmd_op, bus.cmd_w0, bus.cmd_w1}),
                        64'({1'b1, pcmd}));
                if (bus.cmd_valid && bus.cmd_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("cmd_unexpected", 64'(exp_q.size()), 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("cmd_payload",
                            64'({bus.cmd_op, bus.cmd_w0, bus.cmd_w1}), 64'(e));
                    end
                end
                pv   = bus.cmd_valid;
                pr   = bus.cmd_ready;
                pcmd = {bus.cmd_op, bus.cmd_w0, bus.cmd_w1};
            end
        end
    end

    // ---------------- stimulus ----------------
    int base_push, base_pop, base_viol;

    task automatic rom_clear();
        for (int i = 0; i < 4096; i++) rom[i] = 16'hB000;
    endtask

    task automatic start_run(input logic [11:0] a);
        exp_q.delete();
        ref_run(a);
        @(negedge clk);
        base_push = n_push; base_pop = n_pop; base_viol = viol;
        start_addr = a;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic finish_run(input string name);
        int n;
        n = 0;
        while (!halted && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_halted"},    64'(halted),            64'd1);
        chk({name, "_stack_err"}, 64'(stack_err),         64'(exp_err));
        chk({name, "_pc"},        64'(bus.pc_addr),       64'(exp_pc));
        chk({name, "_pushes"},    64'(n_push - base_push), 64'(exp_push));
        chk({name, "_pops"},      64'(n_pop - base_pop),   64'(exp_pop));
        chk({name, "_strobes"},   64'(viol - base_viol),   64'd0);
        chk({name, "_cmds_left"}, 64'(exp_q.size()),       64'd0);
        if (exp_push > 0)
            chk({name, "_push_val"}, 64'(last_push), 64'(exp_last_push));
    endtask

    task automatic wait_cmd_valid(input string name);
        int n;
        n = 0;
        while (!bus.cmd_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_cmd_valid"}, 64'(bus.cmd_valid), 64'd1);
    endtask

    task automatic gen_prog(output logic [11:0] s);
        logic [11:0] pos;
        logic [11:0] tgt;
        int          nsub;
        rom_clear();
        pos  = 12'h900;
        nsub = $urandom_range(1, 3);
        for (int k = 0; k < nsub; k++) begin
            rom[pos] = {4'hF, 12'($urandom)};
            pos = pos + 12'd1;
        end
        rom[pos] = 16'hD000;
        s   = 12'($urandom_range(0, 12'h600));
        pos = s;
        for (int k = 0; k < 8; k++) begin
            case ($urandom_range(0, 4))
                0: begin
                    rom[pos]         = {4'($urandom_range(0, 9)), 12'($urandom)};
                    rom[pos + 12'd1] = 16'($urandom);
                    pos = pos + 12'd2;
                end
                1: begin
                    rom[pos]         = {4'hA, 12'($urandom)};
                    rom[pos + 12'd1] = 16'($urandom);
                    pos = pos + 12'd2;
                end
                2: begin
                    rom[pos] = {4'hF, 12'($urandom)};
                    pos = pos + 12'd1;
                end
                3: begin
                    rom[pos] = {4'hC, 12'h900};
                    pos = pos + 12'd1;
                end
                default: begin
                    tgt = pos + 12'($urandom_range(2, 5));
                    rom[pos] = {4'hE, tgt};
                    pos = tgt;
                end
            endcase
        end
        rom[pos] = 16'hB000;
    endtask

    initial begin
        logic [11:0] s;
        rst_n = 1'b0;
        go = 1'b0;
        start_addr = '0;
        rom_clear();
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            64'({halted, stack_err, bus.cmd_valid, bus.latch0, bus.load_pc,
                 bus.dmaload, bus.dmapush, bus.count_in, bus.cmd_op}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // SVEC then HALT
        rom_clear();
        rom[12'habc] = 16'hF123;
        rom[12'habd] = 16'hB000;
        rdy_mode = 0;
        start_run(12'habc);
        finish_run("svec");

        // JSRL / RTSL round trip
        rom_clear();
        rom[12'h000] = 16'hC010;
        rom[12'h010] = 16'hD000;
        rom[12'h001] = 16'hB000;
        start_run(12'h000);
        finish_run("call_ret");

        // five nested calls overflow a 4-deep stack
        rom_clear();
        rom[12'h000] = 16'hC010;
        rom[12'h010] = 16'hC020;
        rom[12'h020] = 16'hC030;
        rom[12'h030] = 16'hC040;
        rom[12'h040] = 16'hC050;
        start_run(12'h000);
        finish_run("overflow");

        // return with an empty stack
        rom_clear();
        rom[12'h050] = 16'hD000;
        start_run(12'h050);
        finish_run("underflow");

        // two-word VCTR with back-pressure; a stray go is ignored
        rom_clear();
        rom[12'h200] = 16'h6123;
        rom[12'h201] = 16'h0456;
        rom[12'h202] = 16'hB000;
        rdy_mode = 2;
        start_run(12'h200);
        wait_cmd_valid("vctr");
        start_addr = 12'h000;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (4) @(negedge clk);
        chk("vctr_pc_adv", 64'(bus.pc_addr), 64'h202);
        chk("vctr_held",   64'(bus.cmd_valid), 64'd1);
        rdy_mode = 0;
        finish_run("vctr");

        // reset while a command is pending, then a clean restart
        rom_clear();
        rom[12'h300] = 16'hF777;
        rom[12'h301] = 16'hB000;
        rdy_mode = 2;
        start_run(12'h300);
        wait_cmd_valid("rst");
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs",
            64'({halted, stack_err, bus.cmd_valid, bus.latch0, bus.load_pc,
                 bus.dmaload, bus.dmapush, bus.count_in, bus.cmd_op}), 64'd0);
        chk("rst_mid_words", 64'({bus.cmd_w0, bus.cmd_w1}), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        rdy_mode = 0;
        start_run(12'h300);
        finish_run("restart");

        // random display lists with random back-pressure
        rdy_mode = 1;
        for (int r = 0; r < 6; r++) begin
            gen_prog(s);
            start_run(s);
            finish_run($sformatf("rand%0d", r));
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
